// File: rtl/uart_tx_bus.sv
// Bus-mapped 8N1 UART transmitter with TX FIFO, status register and "all sent" interrupt.
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_bus #(
  parameter logic [7:0]  BASE_ADDR    = 8'hB0,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic       TX_OUT,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned BitCntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [7:0] AddrData = BASE_ADDR;
  localparam logic [7:0] AddrStat = BASE_ADDR + 8'd1;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
`ifdef UART_PARITY_EN
  localparam logic [2:0] StParity = 3'd3;
`endif
  localparam logic [2:0] StStop   = 3'd4;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [2:0]         state_q, state_d;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         shift_q, shift_d;
`ifdef UART_PARITY_EN
  logic               par_q, par_d;
`endif
  logic               tx_q, tx_d;
  logic               irq_q, irq_d;
  logic               rd_en_q, rd_en_d;
  logic [7:0]         rd_data_q, rd_data_d;

  logic wr_data, wr_stat, rd_hit;
  logic empty, full, busy, bit_done;
  logic pop, push_ok, frame_done;
  logic [7:0] head;

  assign wr_data  = BUS_WE && (BUS_ADDR == AddrData);
  assign wr_stat  = BUS_WE && (BUS_ADDR == AddrStat);
  assign rd_hit   = !BUS_WE && ((BUS_ADDR == AddrData) || (BUS_ADDR == AddrStat));
  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(FIFO_DEPTH));
  assign busy     = (state_q != StIdle);
  assign bit_done = (bit_cnt_q == BitCntW'(CLKS_PER_BIT - 1));
  assign head     = mem_q[rd_ptr_q];

  // Serialiser FSM; tx_d is the line level for the cycle following this edge.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
`ifdef UART_PARITY_EN
    par_d      = par_q;
`endif
    tx_d       = tx_q;
    pop        = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop       = 1'b1;
          state_d   = StStart;
          bit_cnt_d = '0;
          tx_d      = 1'b0;
        end
      end
      StStart: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          idx_d     = 3'd0;
          state_d   = StData;
          tx_d      = shift_q[0];
        end else begin
          bit_cnt_d = bit_cnt_q + BitCntW'(1);
        end
      end
      StData: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          if (idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = StParity;
            tx_d    = par_q;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BitCntW'(1);
        end
      end
`ifdef UART_PARITY_EN
      StParity: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          state_d   = StStop;
          tx_d      = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + BitCntW'(1);
        end
      end
`endif
      StStop: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            state_d = StStart;
            tx_d    = 1'b0;
          end else begin
            frame_done = 1'b1;
            state_d    = StIdle;
            tx_d       = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BitCntW'(1);
        end
      end
      default: begin
        state_d   = StIdle;
        bit_cnt_d = '0;
        tx_d      = 1'b1;
      end
    endcase
    if (pop) begin
      shift_d = head;
`ifdef UART_PARITY_EN
      par_d   = ^head;
`endif
    end
  end

  // A push into a full FIFO still lands when the head leaves on the same edge.
  always_comb begin
    push_ok  = wr_data && (!full || pop);
    wr_ptr_d = wr_ptr_q + (push_ok ? PtrW'(1) : PtrW'(0));
    rd_ptr_d = rd_ptr_q + (pop ? PtrW'(1) : PtrW'(0));
    count_d  = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CntW'(1);
    end
    ovf_d = ovf_q;
    if (wr_stat && BUS_DATA[3]) begin
      ovf_d = 1'b0;
    end
    if (wr_data && !push_ok) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    irq_d = irq_q;
    if (BUS_INTERRUPT_ACK) begin
      irq_d = 1'b0;
    end
    if (frame_done && !wr_data) begin
      irq_d = 1'b1;
    end
  end

  always_comb begin
    rd_en_d   = rd_hit;
    rd_data_d = rd_data_q;
    if (rd_hit) begin
      if (BUS_ADDR == AddrData) begin
        rd_data_d = 8'(count_q);
      end else begin
        rd_data_d = {4'b0000, ovf_q, busy, empty, full};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
`ifdef UART_PARITY_EN
      par_q     <= 1'b0;
`endif
      tx_q      <= 1'b1;
      irq_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
`ifdef UART_PARITY_EN
      par_q     <= par_d;
`endif
      tx_q      <= tx_d;
      irq_q     <= irq_d;
      rd_en_q   <= rd_en_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && push_ok) begin
      mem_q[wr_ptr_q] <= BUS_DATA;
    end
  end

  // Never contend with the processor on a write cycle.
  assign BUS_DATA            = (rd_en_q && !BUS_WE) ? rd_data_q : 8'bzzzz_zzzz;
  assign TX_OUT              = tx_q;
  assign BUS_INTERRUPT_RAISE = irq_q;

endmodule

// File: tb/tb_uart_tx_bus.sv
// Bench for uart_tx_bus: register table, directed frame/IRQ/reset sequences and a random run
// checked cycle by cycle against a frame-timeline reference model.
module tb_uart_tx_bus;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam logic [7:0] AddrD = 8'hB0;
  localparam logic [7:0] AddrS = 8'hB1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       we = 1'b0;
  logic       ack = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] tb_val = 8'h00;
  logic       tb_en = 1'b1;
  wire  [7:0] bus;
  logic       tx, irq_o;
  logic [7:0] bus_s;

  int vectors = 0;
  int miscompares = 0;

  assign bus = tb_en ? tb_val : 8'bzzzz_zzzz;
  always #5 clk = ~clk;

  uart_tx_bus #(
    .BASE_ADDR   (8'hB0),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .CLK                (clk),
    .RESET              (rst),
    .BUS_DATA           (bus),
    .BUS_ADDR           (addr),
    .BUS_WE             (we),
    .TX_OUT             (tx),
    .BUS_INTERRUPT_RAISE(irq_o),
    .BUS_INTERRUPT_ACK  (ack)
  );

  // Reference model: a byte queue plus the start edge of the frame on the wire.
  logic [7:0] m_q[$];
  logic       m_act = 1'b0;
  int         m_s = 0;
  int         m_n = 0;
  logic       m_fb[11];
  logic       m_ovf = 1'b0;
  logic       m_irq = 1'b0;
  logic       m_rd = 1'b0;
  logic [7:0] m_rdv = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, m_n);
    end
  endtask

  function automatic logic exp_tx();
    if (!m_act) return 1'b1;
    return m_fb[(m_n - m_s) / CPB];
  endfunction

  task automatic model_edge(input logic w, input logic [7:0] a, input logic [7:0] d,
                            input logic k, input logic r);
    logic ended, push, popd, set;
    logic [7:0] b;
    m_n++;
    if (r) begin
      m_q.delete();
      m_act = 1'b0;
      m_ovf = 1'b0;
      m_irq = 1'b0;
      m_rd  = 1'b0;
      return;
    end
    m_rd = !w && (a == AddrD || a == AddrS);
    if (m_rd) begin
      if (a == AddrD) m_rdv = 8'(m_q.size());
      else m_rdv = {4'b0000, m_ovf, m_act, (m_q.size() == 0), (m_q.size() == DEPTH)};
    end
    push  = w && (a == AddrD);
    ended = m_act && (m_n == m_s + NB * CPB);
    if (ended) m_act = 1'b0;
    popd = 1'b0;
    if (!m_act && m_q.size() > 0) begin
      b = m_q.pop_front();
      popd = 1'b1;
      m_act = 1'b1;
      m_s = m_n;
      m_fb[0] = 1'b0;
      for (int i = 0; i < 8; i++) m_fb[1+i] = b[i];
`ifdef UART_PARITY_EN
      m_fb[9]  = ^b;
      m_fb[10] = 1'b1;
`else
      m_fb[9]  = 1'b1;
      m_fb[10] = 1'b1;
`endif
    end
    set = ended && !popd && !push;
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(d);
      else m_ovf = 1'b1;
    end
    if (w && a == AddrS && d[3]) m_ovf = 1'b0;
    if (k) m_irq = 1'b0;
    if (set) m_irq = 1'b1;
  endtask

  // One bus cycle: drive at the negedge, clock, then check everything at the next negedge.
  task automatic tick(input logic w, input logic [7:0] a, input logic [7:0] d,
                      input logic k, input logic r);
    rst    = r;
    we     = w;
    addr   = a;
    ack    = k;
    tb_val = w ? d : 8'h00;
    tb_en  = w || !(a == AddrD || a == AddrS);
    @(posedge clk);
    model_edge(w, a, d, k, r);
    @(negedge clk);
    bus_s = bus;
    check("tx", 32'(tx), 32'(exp_tx()));
    check("irq", 32'(irq_o), 32'(m_irq));
    if (m_rd) check("rdata", 32'(bus_s), 32'(m_rdv));
    else if (tb_en) check("bus_nodrive", 32'(bus_s), 32'(tb_val));
  endtask

  task automatic idle();
    tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    logic       chk;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [10:0] pat;
    int rises, lows, lim, r;
    logic prev;

    for (int i = 0; i < 10; i++) tbl[i] = '{1'b1, AddrD, 8'(8'h10 + i), 1'b0, 8'h00};
    tbl[10] = '{1'b0, AddrS, 8'h00, 1'b1, 8'h0D};
    tbl[11] = '{1'b1, AddrS, 8'h08, 1'b0, 8'h00};
    tbl[12] = '{1'b0, AddrS, 8'h00, 1'b1, 8'h05};
    tbl[13] = '{1'b0, AddrD, 8'h00, 1'b1, 8'h08};
    tbl[14] = '{1'b1, AddrS, 8'h00, 1'b1, 8'h00};

    @(negedge clk);
    // Reset and a single 0x55 frame.
    tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_irq", 32'(irq_o), 32'd0);
    tick(1'b1, AddrD, 8'h55, 1'b0, 1'b0);
    check("a_tx_edge_k", 32'(tx), 32'd1);
`ifdef UART_PARITY_EN
    pat = 11'h4AA;
`else
    pat = 11'h2AA;
`endif
    for (int t = 0; t < NB * CPB; t++) begin
      idle();
      check("a_bit", 32'(tx), 32'(pat[t/CPB]));
    end
    idle();
    check("a_irq", 32'(irq_o), 32'd1);
    tick(1'b0, AddrS, 8'h00, 1'b0, 1'b0);
    check("a_status", 32'(bus_s), 32'h02);

    // Three back-to-back frames, one interrupt.
    tick(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    tick(1'b1, AddrD, 8'hA1, 1'b0, 1'b0);
    tick(1'b1, AddrD, 8'hA2, 1'b0, 1'b0);
    tick(1'b1, AddrD, 8'hA3, 1'b0, 1'b0);
    rises = 0;
    prev = irq_o;
    for (int t = 0; t < 3 * NB * CPB + 20; t++) begin
      idle();
      if (irq_o && !prev) rises++;
      prev = irq_o;
    end
    check("b_irq_rises", 32'(rises), 32'd1);

    // Overflow table from a clean start.
    tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      tick(tbl[i].w, tbl[i].a, tbl[i].d, 1'b0, 1'b0);
      if (tbl[i].chk) check("tbl", 32'(bus_s), 32'(tbl[i].exp));
    end
    lim = 0;
    while (!irq_o && lim < 10 * NB * CPB) begin
      idle();
      lim++;
    end
    check("c_drain_irq", 32'(irq_o), 32'd1);

    // Read timing with three bytes queued.
    tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b1, AddrD, 8'(8'h30 + i), 1'b0, 1'b0);
    tick(1'b0, AddrD, 8'h00, 1'b0, 1'b0);
    check("d_count", 32'(bus_s), 32'h03);
    tick(1'b1, AddrS, 8'h00, 1'b0, 1'b0);
    check("d_we_nodrive", 32'(bus_s), 32'h00);
    tick(1'b0, AddrD, 8'h00, 1'b0, 1'b0);
    idle();
    check("d_release", 32'(bus_s), 32'h00);

    // Reset in the middle of data bit 3.
    tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    tick(1'b1, AddrD, 8'hC3, 1'b0, 1'b0);
    tick(1'b1, AddrD, 8'h11, 1'b0, 1'b0);
    tick(1'b1, AddrD, 8'h22, 1'b0, 1'b0);
    for (int t = 0; t < 16; t++) idle();
    check("e_bit3", 32'(tx), 32'd0);
    tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    check("e_rst_tx", 32'(tx), 32'd1);
    check("e_rst_irq", 32'(irq_o), 32'd0);
    tick(1'b0, AddrD, 8'h00, 1'b0, 1'b0);
    check("e_count", 32'(bus_s), 32'h00);
    lows = 0;
    for (int t = 0; t < 60; t++) begin
      idle();
      if (!tx) lows++;
    end
    check("e_quiet", 32'(lows), 32'd0);

    // Ack on the interrupt-set edge; parity of 0x07.
    tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    tick(1'b1, AddrD, 8'h07, 1'b0, 1'b0);
    for (int j = 0; j < NB * CPB; j++) begin
      idle();
`ifdef UART_PARITY_EN
      if (j / CPB == 9) check("f_parity", 32'(tx), 32'd1);
`endif
    end
    tick(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    check("f_set_wins", 32'(irq_o), 32'd1);
    idle();
    check("f_hold", 32'(irq_o), 32'd1);
    tick(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    check("f_ack", 32'(irq_o), 32'd0);

    // Random traffic against the model.
    tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    for (int t = 0; t < 4000; t++) begin
      r = int'($urandom_range(0, 999));
      if (r < 100)      tick(1'b1, AddrD, 8'($urandom), 1'b0, 1'b0);
      else if (r < 130) tick(1'b1, AddrS, 8'($urandom), 1'b0, 1'b0);
      else if (r < 200) tick(1'b0, AddrD, 8'h00, 1'b0, 1'b0);
      else if (r < 260) tick(1'b0, AddrS, 8'h00, 1'b0, 1'b0);
      else if (r < 290) tick(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
      else if (r < 300) tick(1'b0, 8'hB2, 8'h00, 1'b0, 1'b0);
      else if (r < 303) tick(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      else              idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
